cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, cycles mem_req may wait for mem_ready before fault.
REQ-002 Parameter CNT_W, default 8, width of retired-instruction counter.
REQ-003 Port clock  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port opcode  in  4  opcode field of instruction register.
REQ-006 Port zero  in  1  ALU zero flag.
REQ-007 Port mem_ready  in  1  memory completes the current request this cycle.
REQ-008 Ports ir_we, pc_we, reg_we, mem_req, mem_we  out  1 each  datapath strobes.
REQ-009 Port pc_sel  out  1  0 = PC+1, 1 = jump target.
REQ-010 Port addr_sel  out  1  0 = PC, 1 = operand address.
REQ-011 Port wb_sel  out  1  0 = ALU result, 1 = memory data.
REQ-012 Port alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-013 Ports halted, fault  out  1 each  sticky status; state  out  3  current state; instr_cnt  out  CNT_W  retired count.

Function
REQ-014 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7; all strobes 0 unless stated.
REQ-015 IDLE -> FETCH next cycle.
REQ-016 FETCH: mem_req=1, addr_sel=0; on mem_ready, same cycle ir_we=1, pc_we=1, pc_sel=0, go DECODE; else stay.
REQ-017 DECODE (1 cycle): opcode 1-4 (ADD/SUB/AND/OR) -> EXEC; 5 LD, 6 ST -> MEM; 0 NOP -> IDLE.
REQ-018 DECODE: 7 JMP -> pc_we=1, pc_sel=1, -> IDLE; 8 BEQ -> pc_we=zero, pc_sel=1, -> IDLE.
REQ-019 DECODE: 15 HALT -> HALT; 9-14 illegal -> FAULT.
REQ-020 EXEC (1 cycle): alu_op = opcode-1, -> WB; WB: reg_we=1, wb_sel=0, alu_op held, -> IDLE.
REQ-021 MEM: mem_req=1, addr_sel=1, mem_we=(opcode==ST); on mem_ready: LD asserts reg_we=1, wb_sel=1 same cycle; both -> IDLE.
REQ-022 Timeout: counter increments each cycle mem_req=1 and mem_ready=0, clears on mem_ready or leaving FETCH/MEM; reaching MEM_TIMEOUT -> FAULT next edge, no strobes.
REQ-023 mem_ready on the cycle the counter reaches MEM_TIMEOUT wins: request completes, no fault.
REQ-024 instr_cnt increments by 1 on every transition into IDLE from DECODE/WB/MEM and on entry to HALT; wraps modulo 2^CNT_W.
REQ-025 HALT and FAULT absorbing until reset; halted=1 in HALT, fault=1 in FAULT; strobes 0.
REQ-026 Strobes are combinational from state, opcode, zero, mem_ready; no bubble between FETCH completion and DECODE.

Reset
REQ-027 reset=0 forces state=IDLE, instr_cnt=0, timeout count=0, halted=fault=0, all strobes 0, asynchronously, including mid-FETCH/MEM.
REQ-028 First FETCH occurs 1 cycle after reset deasserts.

Configuration
REQ-029 Macro CPU_CTRL_SINGLE_STEP_EN: when defined, input port step (1 bit) exists and IDLE -> FETCH only on a cycle with step=1; when undefined, port absent and IDLE -> FETCH unconditionally.

Structure
REQ-030 Package cpu_pkg holds opcode constants, state encoding, alu_op codes.
REQ-031 Sub-module cpu_ctrl_timeout holds the memory watchdog counter (inputs req, ready, clear; output expired).

Verification
REQ-032 ADD with mem_ready in 1st FETCH cycle -> IDLE,FETCH,DECODE,EXEC,WB,IDLE; reg_we=1 only in WB; instr_cnt 0->1.
REQ-033 LD, mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles, reg_we=1 and wb_sel=1 on the ready cycle only.
REQ-034 BEQ with zero=0 then zero=1 -> pc_we=0 then pc_we=1 with pc_sel=1 in DECODE.
REQ-035 FETCH with mem_ready held 0 -> FAULT after 15 waiting cycles, fault=1; mem_ready=1 exactly at cycle 15 -> no fault.
REQ-036 Opcode 15 -> halted=1, instr_cnt+1, frozen; opcode 10 -> fault=1; reset pulse mid-MEM -> IDLE, counters 0.
REQ-037 With CPU_CTRL_SINGLE_STEP_EN defined, step=0 -> stays in IDLE; one step pulse -> exactly one instruction retires.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: states, opcodes and ALU codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_LD   = 4'd5;
  localparam logic [3:0] OP_ST   = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // ALU opcodes 1..4 map directly onto alu_op 0..3.
  function automatic logic [1:0] alu_of(input logic [3:0] op);
    logic [3:0] t;
    t = op - 4'd1;
    return t[1:0];
  endfunction

endpackage

// File: rtl/cpu_ctrl_timeout.sv
// Memory watchdog: counts cycles a request waits for ready and flags expiry at MEM_TIMEOUT.
module cpu_ctrl_timeout #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at the limit; the controller leaves the state on expiry, which clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || ready) begin
      cnt_d = '0;
    end else if (req && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control FSM with memory watchdog and retired-instruction counter.
// Optional CPU_CTRL_SINGLE_STEP_EN adds a step input gating IDLE -> FETCH.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_sel,
  output logic             addr_sel,
  output logic             wb_sel,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             expired;
  logic             retire;

  cpu_ctrl_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clock),
    .rst_n   (reset),
    .req     (mem_req),
    .ready   (mem_ready),
    .clear   (state_d != state_q),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    pc_sel   = 1'b0;
    addr_sel = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = ALU_ADD;
    unique case (state_q)
      S_IDLE: begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
        if (step) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC;
          OP_LD, OP_ST:                  state_d = S_MEM;
          OP_NOP:                        state_d = S_IDLE;
          OP_JMP: begin
            pc_we   = 1'b1;
            pc_sel  = 1'b1;
            state_d = S_IDLE;
          end
          OP_BEQ: begin
            pc_we   = zero;
            pc_sel  = 1'b1;
            state_d = S_IDLE;
          end
          OP_HALT:                       state_d = S_HALT;
          default:                       state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        alu_op  = alu_of(opcode);
        state_d = S_WB;
      end
      S_WB: begin
        alu_op  = alu_of(opcode);
        reg_we  = 1'b1;
        state_d = S_IDLE;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_ST);
        if (mem_ready) begin
          reg_we  = (opcode == OP_LD);
          wb_sel  = (opcode == OP_LD);
          state_d = S_IDLE;
        end else if (expired) begin
          state_d = S_FAULT;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // An instruction retires when it returns to IDLE after decode, or when it halts.
  always_comb begin
    retire = 1'b0;
    if ((state_q == S_DECODE || state_q == S_WB || state_q == S_MEM) && state_d == S_IDLE)
      retire = 1'b1;
    if (state_q != S_HALT && state_d == S_HALT)
      retire = 1'b1;
    instr_cnt_d = retire ? instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : instr_cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;
  assign halted    = (state_q == S_HALT);
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: per-instruction expected traces compared every cycle.
module tb_cpu_ctrl;

  localparam int MEM_T = 15;
  localparam int CW    = 8;

  localparam logic [2:0] E_IDLE = 3'd0, E_FETCH = 3'd1, E_DEC = 3'd2, E_EXEC = 3'd3;
  localparam logic [2:0] E_MEM = 3'd4, E_WB = 3'd5, E_HALT = 3'd6, E_FAULT = 3'd7;

  // Strobe bit positions: {ir_we, pc_we, reg_we, mem_req, mem_we, pc_sel, addr_sel, wb_sel}
  localparam logic [7:0] B_IR = 8'h80, B_PC = 8'h40, B_REG = 8'h20, B_REQ = 8'h10;
  localparam logic [7:0] B_WE = 8'h08, B_PCS = 8'h04, B_ADDR = 8'h02, B_WB = 8'h01;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic          step = 1'b0;
`endif
  logic [3:0]    opcode = 4'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          ir_we, pc_we, reg_we, mem_req, mem_we, pc_sel, addr_sel, wb_sel;
  logic [1:0]    alu_op;
  logic          halted, fault;
  logic [2:0]    state;
  logic [CW-1:0] instr_cnt;

  logic [22:0]   exp_q[$];
  logic [CW-1:0] m_cnt;
  int            n_tests = 0;
  int            n_fail = 0;

  cpu_ctrl #(.MEM_TIMEOUT(MEM_T), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .reg_we    (reg_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .pc_sel    (pc_sel),
    .addr_sel  (addr_sel),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .halted    (halted),
    .fault     (fault),
    .state     (state),
    .instr_cnt (instr_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected observable outputs for one cycle in a given state.
  function automatic logic [22:0] ev(input logic [2:0] st, input logic [7:0] strb,
                                     input logic [1:0] alu);
    return {st, strb, alu, st == E_HALT, st == E_FAULT, m_cnt};
  endfunction

  // Drive this cycle's inputs, record its expectation, advance to the next cycle start.
  task automatic step_cyc(input logic rdy, input logic [22:0] e);
    mem_ready = rdy;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // A request phase that waits `waits` cycles; past MEM_T waits the watchdog faults.
  task automatic wait_phase(input logic [2:0] st, input logic [7:0] base, input int waits,
                            output bit timed_out);
    int n;
    timed_out = (waits > MEM_T);
    n = timed_out ? MEM_T + 1 : waits;
    for (int i = 0; i < n; i++) step_cyc(1'b0, ev(st, base, 2'd0));
    if (timed_out) repeat (3) step_cyc(1'b0, ev(E_FAULT, 8'h00, 2'd0));
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    bit to;
    logic [7:0] mb;
    opcode = op;
    zero   = z;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    step_cyc(1'b0, ev(E_IDLE, 8'h00, 2'd0));
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    wait_phase(E_FETCH, B_REQ, fw, to);
    if (to) return;
    step_cyc(1'b1, ev(E_FETCH, B_IR | B_PC | B_REQ, 2'd0));
    step_cyc(1'b0, ev(E_DEC, (op == 4'd7) ? (B_PC | B_PCS) :
                             (op == 4'd8) ? ((z ? B_PC : 8'h00) | B_PCS) : 8'h00, 2'd0));
    if (op == 4'd0 || op == 4'd7 || op == 4'd8) begin
      m_cnt++;
    end else if (op >= 4'd1 && op <= 4'd4) begin
      step_cyc(1'b0, ev(E_EXEC, 8'h00, 2'(op - 4'd1)));
      step_cyc(1'b0, ev(E_WB, B_REG, 2'(op - 4'd1)));
      m_cnt++;
    end else if (op == 4'd5 || op == 4'd6) begin
      mb = B_REQ | B_ADDR | ((op == 4'd6) ? B_WE : 8'h00);
      wait_phase(E_MEM, mb, mw, to);
      if (to) return;
      step_cyc(1'b1, ev(E_MEM, mb | ((op == 4'd5) ? (B_REG | B_WB) : 8'h00), 2'd0));
      m_cnt++;
    end else if (op == 4'd15) begin
      m_cnt++;
      repeat (3) step_cyc(1'($urandom_range(0, 1)), ev(E_HALT, 8'h00, 2'd0));
    end else begin
      repeat (3) step_cyc(1'($urandom_range(0, 1)), ev(E_FAULT, 8'h00, 2'd0));
    end
  endtask

  // Asserts reset mid-cycle (asynchronously), checks the cleared outputs, releases on an edge.
  task automatic do_reset();
    reset     = 1'b0;
    mem_ready = 1'b0;
    #2;
    chk("rst_state", 23'(state), 23'd0);
    chk("rst_cnt", 23'(instr_cnt), 23'd0);
    chk("rst_status", 23'({halted, fault}), 23'd0);
    chk("rst_strobes", 23'({ir_we, pc_we, reg_we, mem_req, mem_we, pc_sel, addr_sel, wb_sel}), 23'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    m_cnt = '0;
  endtask

  initial begin
    m_cnt = '0;
    fork
      forever begin
        @(negedge clock);
        if (exp_q.size() > 0)
          chk("cycle", {state, ir_we, pc_we, reg_we, mem_req, mem_we, pc_sel, addr_sel,
                        wb_sel, alu_op, halted, fault, instr_cnt}, exp_q.pop_front());
      end
    join_none

    do_reset();
    run_instr(4'd1, 1'b0, 0, 0);
    chk("add_cnt", 23'(instr_cnt), 23'd1);
    run_instr(4'd2, 1'b0, 2, 0);
    run_instr(4'd3, 1'b1, 0, 0);
    run_instr(4'd4, 1'b0, 1, 0);
    run_instr(4'd5, 1'b0, 0, 3);
    run_instr(4'd6, 1'b0, 0, 0);
    run_instr(4'd6, 1'b1, 1, 2);
    run_instr(4'd8, 1'b0, 0, 0);
    run_instr(4'd8, 1'b1, 0, 0);
    run_instr(4'd7, 1'b0, 0, 0);
    run_instr(4'd0, 1'b0, 0, 0);
    run_instr(4'd1, 1'b0, 15, 0);
    run_instr(4'd5, 1'b0, 0, 15);
    chk("cnt_13", 23'(instr_cnt), 23'd13);
    for (int i = 0; i < 243; i++) run_instr(4'd0, 1'($urandom_range(0, 1)), 0, 0);
    chk("cnt_wrap", 23'(instr_cnt), 23'd0);
    run_instr(4'd15, 1'b0, 0, 0);
    chk("halt_flag", 23'({halted, fault}), 23'b10);
    chk("halt_cnt", 23'(instr_cnt), 23'd1);

    do_reset();
    run_instr(4'd10, 1'b0, 0, 0);
    chk("illegal_fault", 23'({halted, fault}), 23'b01);
    do_reset();
    run_instr(4'd1, 1'b0, 16, 0);
    chk("fetch_to_state", 23'(state), 23'd7);
    do_reset();
    run_instr(4'd5, 1'b0, 0, 16);
    chk("mem_to_fault", 23'(fault), 23'd1);

    do_reset();
    run_instr(4'd1, 1'b0, 0, 0);
    opcode = 4'd5;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    step_cyc(1'b0, ev(E_IDLE, 8'h00, 2'd0));
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    step_cyc(1'b1, ev(E_FETCH, B_IR | B_PC | B_REQ, 2'd0));
    step_cyc(1'b0, ev(E_DEC, 8'h00, 2'd0));
    repeat (10) step_cyc(1'b0, ev(E_MEM, B_REQ | B_ADDR, 2'd0));
    do_reset();
    run_instr(4'd1, 1'b0, 10, 0);
    run_instr(4'd5, 1'b0, 0, 10);
    chk("post_rst_cnt", 23'(instr_cnt), 23'd2);

`ifdef CPU_CTRL_SINGLE_STEP_EN
    step = 1'b0;
    repeat (4) step_cyc(1'b0, ev(E_IDLE, 8'h00, 2'd0));
    run_instr(4'd0, 1'b0, 0, 0);
    repeat (4) step_cyc(1'b0, ev(E_IDLE, 8'h00, 2'd0));
    chk("step_one", 23'(instr_cnt), 23'd3);
`endif

    @(posedge clock);
    #1;
    chk("queue_drained", 23'(exp_q.size()), 23'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
